// File: rtl/avalon_pio_pkg.sv
// Shared register map for the Avalon-MM output PIO.
package avalon_pio_pkg;

  localparam logic [1:0] ADDR_DATA      = 2'd0;
  localparam logic [1:0] ADDR_BLINKMASK = 2'd1;
  localparam logic [1:0] ADDR_OUTSET    = 2'd2;
  localparam logic [1:0] ADDR_OUTCLEAR  = 2'd3;

endpackage

// File: rtl/pio_blink_prescaler.sv
// Blink half-period prescaler: phase toggles every BLINK_DIV cycles.
// restart forces the counter to 0 and phase to 1.
module pio_blink_prescaler #(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic phase
);

  localparam int unsigned CntW = $clog2(BLINK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(BLINK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == CntLast) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/avalon_out_pio.sv
// Avalon-MM output PIO with set/clear registers and optional LED blink.
// Blink support is built only when AVALON_OUT_PIO_BLINK_EN is defined.
module avalon_out_pio
  import avalon_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] mask_rd;
  logic [31:0]      rdata_q, rdata_d;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_d = wdata;
        ADDR_OUTSET:   data_d = data_q | wdata;
        ADDR_OUTCLEAR: data_d = data_q & ~wdata;
        default:       ;
      endcase
    end
  end

`ifdef AVALON_OUT_PIO_BLINK_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             restart;
  logic             phase;

  // Writing the mask restarts the blink so new bits start in the on half.
  assign restart = wr_en && (address == ADDR_BLINKMASK);
  assign mask_d  = restart ? wdata : mask_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  pio_blink_prescaler #(
    .BLINK_DIV(BLINK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .restart(restart),
    .phase  (phase)
  );

  assign out_d   = data_q & ~(mask_q & {WIDTH{~phase}});
  assign mask_rd = mask_q;
`else
  localparam int unsigned unused_blink_div = BLINK_DIV;

  assign out_d   = data_q;
  assign mask_rd = '0;
`endif

  always_comb begin
    rdata_d = '0;
    case (address)
      ADDR_DATA:      rdata_d[WIDTH-1:0] = data_q;
      ADDR_BLINKMASK: rdata_d[WIDTH-1:0] = mask_rd;
      default:        ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= RESET_VALUE[WIDTH-1:0];
      out_q   <= RESET_VALUE[WIDTH-1:0];
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      out_q   <= out_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign out_port = out_q;

endmodule

// File: tb/tb_avalon_out_pio.sv
// Self-checking bench for avalon_out_pio (WIDTH=8, BLINK_DIV=4, RESET_VALUE=0).
module tb_avalon_out_pio;
  import avalon_pio_pkg::*;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned BLINK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int checks = 0;
  int errors = 0;

  // Reference model: t counts edges since the last blink restart.
  logic [7:0]  m_data, m_mask, m_out;
  logic [31:0] m_rd;
  int          m_t;

  avalon_out_pio #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(32'h0),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 8'h00;
    m_mask = 8'h00;
    m_out  = 8'h00;
    m_rd   = 32'h0;
    m_t    = 0;
  endtask

  task automatic tick();
    logic [7:0]  nd, nm;
    logic        on_half, wr;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      on_half = ((m_t / BLINK_DIV) % 2) == 0;
`ifdef AVALON_OUT_PIO_BLINK_EN
      m_out = on_half ? m_data : (m_data & ~m_mask);
`else
      m_out = m_data;
`endif
      case (address)
        2'd0:    m_rd = {24'h0, m_data};
        2'd1:    m_rd = {24'h0, m_mask};
        default: m_rd = 32'h0;
      endcase
      wr = chipselect && !write_n;
      nd = m_data;
      nm = m_mask;
      m_t = m_t + 1;
      if (wr) begin
        case (address)
          2'd0: nd = writedata[7:0];
          2'd2: nd = m_data | writedata[7:0];
          2'd3: nd = m_data & ~writedata[7:0];
          default: begin
`ifdef AVALON_OUT_PIO_BLINK_EN
            nm  = writedata[7:0];
            m_t = 0;
`endif
          end
        endcase
      end
      m_data = nd;
      m_mask = nm;
    end
    #1;
    chk("out_port", {24'h0, out_port}, {24'h0, m_out});
    chk("readdata", readdata, m_rd);
  endtask

  task automatic idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [1:0] a);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    tick();
    idle();
  endtask

  initial begin
    model_reset();
    // Reset held with a DATA write pending.
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = ADDR_DATA;
    writedata  = 32'hFF;
    #1;
    chk("rst_out", {24'h0, out_port}, 32'h0);
    chk("rst_rd", readdata, 32'h0);
    repeat (3) tick();
    idle();
    reset_n = 1'b1;
    rd(ADDR_DATA);
    chk("post_rst_rd", readdata, 32'h0);

    // Write and read back; upper bits of writedata are dropped.
    wr(ADDR_DATA, 32'h1A5);
    tick();
    chk("pin_a5", {24'h0, out_port}, 32'hA5);
    rd(ADDR_DATA);
    chk("rd_a5", readdata, 32'hA5);
    chipselect = 1'b0;
    write_n    = 1'b0;
    address    = ADDR_DATA;
    writedata  = 32'hFF;
    tick();
    idle();
    rd(ADDR_DATA);
    chk("cs0_ignored", readdata, 32'hA5);

    // Set then clear.
    wr(ADDR_OUTSET, 32'h0F);
    rd(ADDR_DATA);
    chk("outset", readdata, 32'hAF);
    wr(ADDR_OUTCLEAR, 32'h81);
    rd(ADDR_DATA);
    chk("outclear", readdata, 32'h2E);
    rd(ADDR_OUTSET);
    chk("rd_addr2", readdata, 32'h0);
    rd(ADDR_OUTCLEAR);
    chk("rd_addr3", readdata, 32'h0);

`ifdef AVALON_OUT_PIO_BLINK_EN
    wr(ADDR_DATA, 32'hFF);
    wr(ADDR_BLINKMASK, 32'h03);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("blink", {24'h0, out_port}, (((i / 4) % 2) == 0) ? 32'hFF : 32'hFC);
    end
    repeat (5) tick();
    chk("off_phase", {24'h0, out_port}, 32'hFC);
    wr(ADDR_BLINKMASK, 32'h03);
    tick();
    chk("restart_on", {24'h0, out_port}, 32'hFF);

    // Reset asserted mid off-phase.
    repeat (5) tick();
    chk("off_again", {24'h0, out_port}, 32'hFC);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_out", {24'h0, out_port}, 32'h0);
    chk("async_rst_rd", readdata, 32'h0);
    tick();
    reset_n = 1'b1;
    rd(ADDR_BLINKMASK);
    chk("mask_cleared", readdata, 32'h0);
    wr(ADDR_DATA, 32'hFF);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("no_blink", {24'h0, out_port}, 32'hFF);
    end
`else
    wr(ADDR_BLINKMASK, 32'hFF);
    wr(ADDR_DATA, 32'h55);
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("steady_55", {24'h0, out_port}, 32'h55);
    end
    rd(ADDR_BLINKMASK);
    chk("rd_addr1_zero", readdata, 32'h0);
`endif

    // Randomized accesses against the model.
    for (int i = 0; i < 400; i++) begin
      chipselect = 1'($urandom_range(0, 3) != 0);
      write_n    = 1'($urandom_range(0, 2) == 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      tick();
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
